// File: rtl/dm_hart_stub_if.sv
// Debug-memory bus between the hart-side stub (master) and the debug memory (slave).
//   req   : access strobe, one cycle per access
//   we    : write enable
//   addr  : byte address
//   wdata : write data
//   be    : byte enables
//   rdata : read data, valid the cycle after a read strobe
interface dm_hart_stub_if #(
  parameter int unsigned BusWidth = 32
) ();
  logic                  req;
  logic                  we;
  logic [BusWidth-1:0]   addr;
  logic [BusWidth-1:0]   wdata;
  logic [BusWidth/8-1:0] be;
  logic [BusWidth-1:0]   rdata;

  modport master (
    output req,
    output we,
    output addr,
    output wdata,
    output be,
    input  rdata
  );

  modport slave (
    input  req,
    input  we,
    input  addr,
    input  wdata,
    input  be,
    output rdata
  );
endinterface

// File: rtl/dm_hart_stub.sv
// Hart-side debug-memory initiator. Stands in for a core running the debug ROM park loop:
// on a halt request it writes the Halted flag, then polls its flag byte and either fetches
// and hands off the WhereTo instruction (go), or writes Resuming and returns to running.
// Executor traps are reported with an Exception write.
//   clk_i, rst_ni        : clock, asynchronous active-low reset
//   debug_req_i          : level halt request
//   halted_o, resumed_o  : in debug mode / one-cycle pulse on the resuming write
//   mem                  : debug-memory bus (master side)
//   cmd_valid_o          : fetched instruction pending execution
//   cmd_insn_o           : fetched WhereTo instruction
//   cmd_done_i           : executor finished
//   cmd_exception_i      : executor trapped
module dm_hart_stub #(
  parameter int unsigned         BusWidth      = 32,
  parameter logic [BusWidth-1:0] DmBaseAddress = '0,
  parameter int unsigned         HartId        = 0,
  parameter int unsigned         PollGap       = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  debug_req_i,
  output logic                  halted_o,
  output logic                  resumed_o,
  dm_hart_stub_if.master        mem,
  output logic                  cmd_valid_o,
  output logic [31:0]           cmd_insn_o,
  input  logic                  cmd_done_i,
  input  logic                  cmd_exception_i
);

  localparam logic [BusWidth-1:0] AddrHalted    = DmBaseAddress + BusWidth'(32'h100);
  localparam logic [BusWidth-1:0] AddrGoing     = DmBaseAddress + BusWidth'(32'h108);
  localparam logic [BusWidth-1:0] AddrResuming  = DmBaseAddress + BusWidth'(32'h110);
  localparam logic [BusWidth-1:0] AddrException = DmBaseAddress + BusWidth'(32'h118);
  localparam logic [BusWidth-1:0] AddrWhereTo   = DmBaseAddress + BusWidth'(32'h300);
  // Flags are byte-addressed per hart but read as the aligned word containing our byte.
  localparam logic [BusWidth-1:0] AddrFlags     = DmBaseAddress + BusWidth'(32'h400)
                                                  + BusWidth'(HartId & 32'hFFC);
  localparam int unsigned         FlagLsb       = (HartId % 4) * 8;
  localparam logic [BusWidth-1:0] HartIdData    = BusWidth'(HartId);
  localparam int unsigned         ByteW         = BusWidth / 8;
  localparam int unsigned         GapW          = (PollGap < 2) ? 1 : $clog2(PollGap + 1);
  localparam logic [GapW-1:0]     GapLoad       = GapW'(PollGap - 1);

  typedef enum logic [3:0] {
    StRunning,
    StHaltWr,
    StPollRd,
    StPollWait,
    StGap,
    StGoingWr,
    StWtRd,
    StWtWait,
    StExec,
    StExcWr,
    StResumeWr
  } state_e;

  state_e              r_state, w_state_d;
  logic [GapW-1:0]     r_gap_cnt, w_gap_cnt_d;
  logic [31:0]         r_cmd_insn, w_cmd_insn_d;
  logic                r_req, w_req_d;
  logic                r_we, w_we_d;
  logic [BusWidth-1:0] r_addr, w_addr_d;
  logic [BusWidth-1:0] r_wdata, w_wdata_d;
  logic [ByteW-1:0]    r_be, w_be_d;
  logic                r_halted, r_resumed, r_cmd_valid;
  logic                w_flag_go, w_flag_resume;

  assign w_flag_go     = mem.rdata[FlagLsb];
  assign w_flag_resume = mem.rdata[FlagLsb+1];

  // Next-state
  always_comb begin
    w_state_d    = r_state;
    w_gap_cnt_d  = r_gap_cnt;
    w_cmd_insn_d = r_cmd_insn;
    unique case (r_state)
      StRunning:  if (debug_req_i) w_state_d = StHaltWr;
      StHaltWr:   w_state_d = StPollRd;
      StPollRd:   w_state_d = StPollWait;
      StPollWait: begin
        if (w_flag_go) begin
          w_state_d = StGoingWr;
        end else if (w_flag_resume) begin
          w_state_d = StResumeWr;
        end else if (PollGap > 0) begin
          w_state_d   = StGap;
          w_gap_cnt_d = GapLoad;
        end else begin
          w_state_d = StPollRd;
        end
      end
      StGap: begin
        if (r_gap_cnt == '0) w_state_d = StPollRd;
        else                 w_gap_cnt_d = r_gap_cnt - 1'b1;
      end
      StGoingWr:  w_state_d = StWtRd;
      StWtRd:     w_state_d = StWtWait;
      StWtWait: begin
        w_cmd_insn_d = mem.rdata[31:0];
        w_state_d    = StExec;
      end
      StExec: begin
        if (cmd_exception_i) w_state_d = StExcWr;
        else if (cmd_done_i) w_state_d = StPollRd;
      end
      StExcWr:    w_state_d = StPollRd;
      StResumeWr: w_state_d = StRunning;
      default:    w_state_d = StRunning;
    endcase
  end

  // Outputs are registered, so they are decoded from the state being entered.
  always_comb begin
    w_req_d   = 1'b0;
    w_we_d    = 1'b0;
    w_addr_d  = r_addr;
    w_wdata_d = '0;
    w_be_d    = '0;
    unique case (w_state_d)
      StHaltWr: begin
        w_req_d   = 1'b1;
        w_we_d    = 1'b1;
        w_addr_d  = AddrHalted;
        w_wdata_d = HartIdData;
        w_be_d    = '1;
      end
      StPollRd: begin
        w_req_d  = 1'b1;
        w_addr_d = AddrFlags;
      end
      StGoingWr: begin
        w_req_d  = 1'b1;
        w_we_d   = 1'b1;
        w_addr_d = AddrGoing;
        w_be_d   = '1;
      end
      StWtRd: begin
        w_req_d  = 1'b1;
        w_addr_d = AddrWhereTo;
      end
      StExcWr: begin
        w_req_d  = 1'b1;
        w_we_d   = 1'b1;
        w_addr_d = AddrException;
        w_be_d   = '1;
      end
      StResumeWr: begin
        w_req_d   = 1'b1;
        w_we_d    = 1'b1;
        w_addr_d  = AddrResuming;
        w_wdata_d = HartIdData;
        w_be_d    = '1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state     <= StRunning;
      r_gap_cnt   <= '0;
      r_cmd_insn  <= '0;
      r_req       <= 1'b0;
      r_we        <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_be        <= '0;
      r_halted    <= 1'b0;
      r_resumed   <= 1'b0;
      r_cmd_valid <= 1'b0;
    end else begin
      r_state     <= w_state_d;
      r_gap_cnt   <= w_gap_cnt_d;
      r_cmd_insn  <= w_cmd_insn_d;
      r_req       <= w_req_d;
      r_we        <= w_we_d;
      r_addr      <= w_addr_d;
      r_wdata     <= w_wdata_d;
      r_be        <= w_be_d;
      r_halted    <= (w_state_d != StRunning);
      r_resumed   <= (w_state_d == StResumeWr);
      r_cmd_valid <= (w_state_d == StExec);
    end
  end

  assign mem.req     = r_req;
  assign mem.we      = r_we;
  assign mem.addr    = r_addr;
  assign mem.wdata   = r_wdata;
  assign mem.be      = r_be;
  assign halted_o    = r_halted;
  assign resumed_o   = r_resumed;
  assign cmd_valid_o = r_cmd_valid;
  assign cmd_insn_o  = r_cmd_insn;

endmodule
